regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of write requesters (2..8).
REQ-002 Parameter AW, default 5, SHALL set the register address width; the register count is 2**AW.
REQ-003 Parameter DW, default 32, SHALL set the write data width.
REQ-004 Parameter ZERO_PROTECT, default 1, SHALL suppress write enables to register 0 when set to 1.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-007 req_valid  input  NREQ  SHALL carry the per-requester write-request valid.
REQ-008 req_ready  output  NREQ  SHALL carry the per-requester accept, at most one bit high per cycle.
REQ-009 req_addr  input  NREQ*AW  SHALL carry the packed target addresses; requester i occupies bits [i*AW +: AW].
REQ-010 req_data  input  NREQ*DW  SHALL carry the packed write data; requester i occupies bits [i*DW +: DW].
REQ-011 wr_stall  input  1  SHALL be high while the register file cannot take a write.
REQ-012 wr_valid  output  1  SHALL be high while the output stage holds a write.
REQ-013 wr_we  output  2**AW  SHALL be the one-hot decoded write enable for the register file.
REQ-014 wr_addr  output  AW  SHALL carry the registered write address.
REQ-015 wr_data  output  DW  SHALL carry the registered write data.
REQ-016 grant_id  output  3  SHALL carry the index of the requester whose write is in the output stage.

Function
REQ-017 The output stage SHALL be free when wr_valid=0, or when wr_valid=1 and wr_stall=0.
REQ-018 When the output stage is free, req_ready SHALL be asserted combinationally for exactly one valid requester, picked round-robin starting at pointer rr_ptr; with no valid requester, all req_ready bits SHALL be 0.
REQ-019 When the output stage is not free, req_ready SHALL be all 0.
REQ-020 A transfer SHALL occur on a cycle where req_valid[i]=req_ready[i]=1; the output stage SHALL load that request's address, data and index on the next edge (latency 1) and set wr_valid=1.
REQ-021 On a transfer from requester i, rr_ptr SHALL become (i+1) mod NREQ; otherwise rr_ptr SHALL hold.
REQ-022 Output stage free with no transfer: wr_valid SHALL clear to 0 on the next edge.
REQ-023 wr_valid=1 and wr_stall=1: wr_valid, wr_addr, wr_data, wr_we and grant_id SHALL hold stable.
REQ-024 wr_we SHALL be zero whenever wr_valid=0.
REQ-025 When wr_valid=1, wr_we SHALL have exactly bit wr_addr set.
REQ-026 Exception to REQ-025: when ZERO_PROTECT=1 and wr_addr=0, wr_we SHALL be all zero, and the write SHALL still be consumed with wr_valid=1 for its cycle.
REQ-027 A requester SHALL hold valid, addr and data stable until accepted; the arbiter SHALL NOT depend on this for correctness beyond the accepting cycle.
REQ-028 Back-to-back transfers SHALL sustain one write per cycle while wr_stall=0.

Reset
REQ-029 While rst=1 at an edge, the block SHALL set wr_valid=0, wr_we=0, wr_addr=0, wr_data=0, grant_id=0 and rr_ptr=0.
REQ-030 req_ready SHALL be 0 in any cycle where rst=1.
REQ-031 Reset asserted mid-stall SHALL discard the held write, which SHALL NOT reappear after reset.

Structure
REQ-032 NREQ, AW and DW defaults and the grant-index width SHALL live in shared package regfile_pkg.
REQ-033 The one-hot decode SHALL be a combinational sub-module regfile_wdec, with all-zero output for enable=0 and no latches.
REQ-034 The round-robin pick SHALL be inside regfile_write_arbiter; the output stage SHALL be the only registered datapath.

Verification
REQ-035 Reset: assert rst for 2 cycles with all req_valid=1 -> req_ready=0, wr_valid=0, wr_we=0 throughout; rr_ptr=0 after release.
REQ-036 Single write: req 2 with addr=5, data=0xDEADBEEF -> next cycle wr_valid=1, wr_we=0x00000020, wr_data=0xDEADBEEF, grant_id=2.
REQ-037 Fairness: all 4 requesters valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one write per cycle.
REQ-038 Stall: wr_stall=1 for 3 cycles while wr_valid=1 -> outputs frozen and req_ready=0 throughout; after release, the queued request appears 1 cycle later.
REQ-039 Zero protect: req 1 addr=0, data=0x12345678 -> wr_valid=1, wr_we=0; with ZERO_PROTECT=0 -> wr_we=0x00000001.
REQ-040 Reset mid-stall: rst during a held write at addr=31 -> wr_valid=0 and wr_we=0 next cycle; no write to 31 after rst deasserts.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing defaults for the register-file write arbiter and its decoder.
package regfile_pkg;
  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int GW       = 3;

  function automatic logic [GW-1:0] rr_inc(input logic [GW-1:0] idx, input int nreq);
    return (int'(idx) == nreq - 1) ? '0 : idx + 1'b1;
  endfunction
endpackage

// File: rtl/regfile_wdec.sv
// One-hot write-enable decode, purely combinational; all-zero when en is low.
module regfile_wdec #(
  parameter int AW = 5
) (
  input  logic            en,
  input  logic [AW-1:0]   addr,
  output logic [2**AW-1:0] we
);
  always_comb begin
    we = '0;
    if (en) we[addr] = 1'b1;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter feeding one registered write stage into the register file; latency 1.
// Backpressure: wr_stall freezes the held write and drops every req_ready.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ         = NREQ_DEF,
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int ZERO_PROTECT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 wr_stall,
  output logic                 wr_valid,
  output logic [2**AW-1:0]     wr_we,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data,
  output logic [GW-1:0]        grant_id
);
  logic [GW-1:0] rr_ptr;
  logic          stage_free;
  logic          pick_vld;
  logic [GW-1:0] pick;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          we_en;

  assign stage_free = !wr_valid || !wr_stall;

  // Scan distance k from rr_ptr; the first valid requester found wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    sel_addr = '0;
    sel_data = '0;
    if (!rst && stage_free) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!pick_vld && req_valid[i] && ((int'(rr_ptr) + k) % NREQ) == i) begin
            pick_vld = 1'b1;
            pick     = GW'(i);
            sel_addr = req_addr[i*AW +: AW];
            sel_data = req_data[i*DW +: DW];
          end
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) req_ready[i] = pick_vld && (pick == GW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (stage_free) begin
      wr_valid <= pick_vld;
      if (pick_vld) begin
        wr_addr  <= sel_addr;
        wr_data  <= sel_data;
        grant_id <= pick;
        rr_ptr   <= rr_inc(pick, NREQ);
      end
    end
  end

  // Writes to register 0 still occupy the stage, they just never reach the array.
  assign we_en = wr_valid && !((ZERO_PROTECT != 0) && (wr_addr == '0));

  regfile_wdec #(.AW(AW)) u_wdec (
    .en   (we_en),
    .addr (wr_addr),
    .we   (wr_we)
  );
endmodule
